// File: rtl/axi_lite_pkg.sv
// Shared types and defaults for the AXI4-Lite command master.
//   resp_t         : AXI BRESP/RRESP encoding
//   master_state_t : command master FSM states
//   DEF_*          : default widths / watchdog limit
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_HALT    = 3'd5
    } master_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_TIMEOUT    = 1024;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Watchdog for a single AXI channel wait.
//   clock, reset_n : clock / async active-low reset
//   clear          : restart the count (handshake or new wait state)
//   enable         : count this cycle (block is waiting on the slave)
//   expired        : this is the TIMEOUT_CYCLES-th waiting cycle with no progress
module axi_lite_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= cnt + CW'(1);
    end

    // cnt holds the number of cycles already waited, so the limit is hit
    // while cnt is one short of it.
    assign expired = enable && !clear && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one command (read or write) into an AXI-Lite
// transaction and returns data/response. One transaction outstanding.
//   cmd_*   : command channel in (valid/ready, rnw, addr, wdata)
//   rsp_*   : response pulse, read data, resp code, sticky timeout
//   m_axi_* : AXI4-Lite master port (all outputs registered)
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int C_M_AXI_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    output logic                            rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    master_state_t state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    resp_t         rsp_resp_q, rsp_resp_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic wd_clear, wd_enable, wd_expired;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_done, w_done;

    assign aw_hs = awvalid_q && m_axi_awready;
    assign w_hs  = wvalid_q  && m_axi_wready;
    assign b_hs  = bready_q  && m_axi_bvalid;
    assign ar_hs = arvalid_q && m_axi_arready;
    assign r_hs  = rready_q  && m_axi_rvalid;

    // A channel is finished once its valid has dropped or is handshaking now.
    assign aw_done = !awvalid_q || aw_hs;
    assign w_done  = !wvalid_q  || w_hs;

    assign wd_enable = (state_q == ST_WRITE)   || (state_q == ST_WR_RESP) ||
                       (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

    axi_lite_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_clear      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    cmd_ready_d = 1'b0;
                    wd_clear    = 1'b1;
                    if (cmd_rnw) begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                wd_clear = aw_hs || w_hs;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    wd_clear    = 1'b1;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = resp_t'(m_axi_bresp);
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) begin
                    wd_clear  = 1'b1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    wd_clear    = 1'b1;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = resp_t'(m_axi_rresp);
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: ;  // ST_HALT: frozen until reset
        endcase

        // Expiry implies no handshake this cycle, so every AXI valid/ready
        // keeps its current value and the bus stays protocol-legal.
        if (wd_expired) begin
            state_d       = ST_HALT;
            awvalid_d     = awvalid_q;
            wvalid_d      = wvalid_q;
            bready_d      = bready_q;
            arvalid_d     = arvalid_q;
            rready_d      = rready_q;
            cmd_ready_d   = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
module tb_axi_lite_cmd_master;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready = 1'b1, wvalid, wready = 1'b1;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic          bvalid = 1'b0, bready, arvalid, arready = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rvalid = 1'b0, rready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_cmd(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin errors++; $display("FAIL rst_axi_ctl got %b exp 00000", {awvalid, wvalid, bready, arvalid, rready}); end
        checks++; if ({rsp_valid, rsp_timeout} !== 2'b00) begin errors++; $display("FAIL rst_rsp_flags got %b exp 00", {rsp_valid, rsp_timeout}); end
        checks++; if ({rsp_rdata, rsp_resp, awaddr, wdata} !== '0) begin errors++; $display("FAIL rst_regs got %h/%h/%h/%h exp 0", rsp_rdata, rsp_resp, awaddr, wdata); end
        checks++; if ({awprot, arprot, wstrb} !== 10'b000_000_1111) begin errors++; $display("FAIL rst_const got %b exp 0000001111", {awprot, arprot, wstrb}); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_zero_wait();
        awready = 1'b1; wready = 1'b1;
        drive_cmd(1'b0, 5'h04, 32'hDEADBEEF);
        tick();                                   // accept @0
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr0_ready_drop got %b exp 0", cmd_ready); end
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr0_valids got %b exp 11", {awvalid, wvalid}); end
        checks++; if (awaddr !== 5'h04 || wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr0_payload got %h/%h exp 04/deadbeef", awaddr, wdata); end
        tick();                                   // aw/w hs @1
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr0_after_hs got %b exp 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b00;
        tick();                                   // b hs @2
        bvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr0_rsp got %b/%b/%h exp 1/00/0", rsp_valid, rsp_resp, rsp_rdata); end
        checks++; if (cmd_ready !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL wr0_ready_back got %b/%b exp 1/0", cmd_ready, bready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr0_pulse got %b exp 0", rsp_valid); end
    endtask

    task automatic test_write_aw_delay();
        awready = 1'b0; wready = 1'b1;
        drive_cmd(1'b0, 5'h10, 32'hA5A5_0F0F);
        tick();
        cmd_valid = 1'b0;
        tick();                                   // w hs only
        checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL awd_w_drop got %b exp 10", {awvalid, wvalid}); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (awvalid !== 1'b1 || awaddr !== 5'h10 || bready !== 1'b0) begin errors++; $display("FAIL awd_hold%0d got %b/%h/%b exp 1/10/0", i, awvalid, awaddr, bready); end
        end
        awready = 1'b1;
        tick();                                   // aw hs
        checks++; if (awvalid !== 1'b0 || bready !== 1'b1) begin errors++; $display("FAIL awd_aw_hs got %b/%b exp 0/1", awvalid, bready); end
        bvalid = 1'b1; bresp = 2'b11;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11) begin errors++; $display("FAIL awd_decerr got %b/%b exp 1/11", rsp_valid, rsp_resp); end
        tick();
    endtask

    task automatic test_read_delay();
        int pulses;
        arready = 1'b1;
        drive_cmd(1'b1, 5'h08, 32'hFFFF_FFFF);
        tick();
        cmd_valid = 1'b0;
        checks++; if (arvalid !== 1'b1 || araddr !== 5'h08 || awvalid !== 1'b0) begin errors++; $display("FAIL rd_ar got %b/%h/%b exp 1/08/0", arvalid, araddr, awvalid); end
        tick();                                   // ar hs
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL rd_rready got %b/%b exp 0/1", arvalid, rready); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid === 1'b1) pulses++;
        end
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_resp !== 2'b00) begin errors++; $display("FAIL rd_data got %b/%h/%b exp 1/12345678/00", rsp_valid, rsp_rdata, rsp_resp); end
        pulses++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL rd_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_back_to_back();
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        drive_cmd(1'b0, 5'h00, 32'h0000_0001);
        tick();                                   // write accepted
        drive_cmd(1'b1, 5'h0C, 32'h0);            // held valid
        tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_rsp_ready got %b/%b exp 1/1", rsp_valid, cmd_ready); end
        tick();                                   // read accepted here
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || arvalid !== 1'b1 || araddr !== 5'h0C) begin errors++; $display("FAIL b2b_second got %b/%b/%b/%h exp 0/0/1/0c", rsp_valid, cmd_ready, arvalid, araddr); end
        tick();
        rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || rsp_resp !== 2'b10) begin errors++; $display("FAIL b2b_rd got %b/%h/%b exp 1/cafef00d/10", rsp_valid, rsp_rdata, rsp_resp); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        arready = 1'b1;
        drive_cmd(1'b1, 5'h14, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();                                   // now in RD_DATA
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rmr_in_rd got %b exp 1", rready); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({arvalid, rready, rsp_valid} !== 3'b000 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rmr_async got %b/%b exp 000/1", {arvalid, rready, rsp_valid}, cmd_ready); end
        #1 reset_n = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1 || rready !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL rmr_idle got %b/%b/%b exp 1/0/0", cmd_ready, rready, rsp_timeout); end
    endtask

    task automatic test_timeout();
        int n;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        drive_cmd(1'b0, 5'h1C, 32'h5555_AAAA);
        tick();
        cmd_valid = 1'b0;
        tick();                                   // enters WR_RESP
        n = 0;
        while (rsp_timeout !== 1'b1 && n < 4 * TO) begin
            tick();
            n++;
        end
        checks++; if (n != TO) begin errors++; $display("FAIL to_cycles got %0d exp %0d", n, TO); end
        checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || cmd_ready !== 1'b0) begin errors++; $display("FAIL to_rsp got %b/%b/%b exp 1/10/0", rsp_valid, rsp_resp, cmd_ready); end
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL to_bready_held got %b exp 1", bready); end
        drive_cmd(1'b1, 5'h00, 32'h0);
        tick();
        tick();
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b1 || cmd_ready !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL to_halted got %b/%b/%b/%b exp 0/1/0/0", rsp_valid, rsp_timeout, cmd_ready, arvalid); end
        reset_n = 1'b0;
        #1;
        checks++; if (rsp_timeout !== 1'b0 || cmd_ready !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL to_reset got %b/%b/%b exp 0/1/0", rsp_timeout, cmd_ready, bready); end
        #2 reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_aw_delay();
        test_read_delay();
        test_back_to_back();
        test_reset_mid_read();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
